// File: rtl/deb_pkg.sv
// Shared state encoding and output decode for the
// push-button conditioner channels.
package deb_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PWAIT = 4'd1,
        S_PRESS = 4'd2,
        S_HOLD  = 4'd3,
        S_RPT   = 4'd4,
        S_RWAIT = 4'd5,
        S_SAT   = 4'd6,
        S_RELW  = 4'd7,
        S_REL   = 4'd8
    } state_t;

    // Bit order: {DPB, SCEN, MCEN, CCEN, RLEN}
    function automatic logic [4:0] out_dec(input state_t s);
        logic [4:0] o;
        o = 5'b00000;
        unique case (s)
            S_PRESS: o = 5'b11110;
            S_HOLD:  o = 5'b10000;
            S_RPT:   o = 5'b10110;
            S_RWAIT: o = 5'b10010;
            S_SAT:   o = 5'b10110;
            S_RELW:  o = 5'b10000;
            S_REL:   o = 5'b00001;
            default: o = 5'b00000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/btn_rpt_deb_ch.sv
// One button channel: synchroniser, debounce/repeat FSM,
// cycle timer and repeat counter.
module btn_rpt_deb_ch
    import deb_pkg::*;
#(
    parameter int DEB_CYC  = 8_400_000,
    parameter int HOLD_CYC = 134_000_000,
    parameter int RPT_CYC  = 50_000_000,
    parameter int MAX_RPT  = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN,
    output logic CCEN,
    output logic RLEN
);

    localparam int MAX_A = (DEB_CYC > HOLD_CYC) ? DEB_CYC : HOLD_CYC;
    localparam int MAX_C = (MAX_A > RPT_CYC) ? MAX_A : RPT_CYC;
    localparam int CNT_W = $clog2(MAX_C) + 1;
    localparam int RC_W  = (MAX_RPT == 0) ? 1 : $clog2(MAX_RPT + 1);

    localparam logic [CNT_W-1:0] DEB_T  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_T  = CNT_W'(RPT_CYC - 1);
    localparam logic [RC_W-1:0]  RC_MAX = RC_W'(MAX_RPT);

    logic             pb_m;
    logic             pb_s;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_n;
    logic [RC_W-1:0]  rcnt;
    logic [RC_W-1:0]  rcnt_n;

    (* fsm_encoding = "user" *) state_t state;
    state_t state_n;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pb_m  <= 1'b0;
            pb_s  <= 1'b0;
            state <= S_IDLE;
            timer <= '0;
            rcnt  <= '0;
        end else begin
            pb_m  <= PB;
            pb_s  <= pb_m;
            state <= state_n;
            timer <= timer_n;
            rcnt  <= rcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        rcnt_n  = rcnt;
        unique case (state)
            S_IDLE: begin
                timer_n = '0;
                rcnt_n  = '0;
                if (pb_s) state_n = S_PWAIT;
            end
            S_PWAIT: begin
                timer_n = timer + 1'b1;
                if (!pb_s) begin
                    state_n = S_IDLE;
                    timer_n = '0;
                end else if (timer == DEB_T) begin
                    state_n = S_PRESS;
                end
            end
            S_PRESS: begin
                timer_n = '0;
                state_n = S_HOLD;
            end
            S_HOLD: begin
                // Saturates so an endless hold (no repeats) never wraps
                if (timer != HOLD_T) timer_n = timer + 1'b1;
                if (!pb_s) begin
                    state_n = S_RELW;
                    timer_n = '0;
                end else if (MAX_RPT != 0 && timer == HOLD_T) begin
                    state_n = S_RPT;
                end
            end
            S_RPT: begin
                timer_n = '0;
                rcnt_n  = rcnt + 1'b1;
                state_n = (rcnt_n == RC_MAX) ? S_SAT : S_RWAIT;
            end
            S_RWAIT: begin
                timer_n = timer + 1'b1;
                if (!pb_s) begin
                    state_n = S_RELW;
                    timer_n = '0;
                end else if (timer == RPT_T) begin
                    state_n = S_RPT;
                end
            end
            S_SAT: begin
                timer_n = '0;
                if (!pb_s) state_n = S_RELW;
            end
            S_RELW: begin
                timer_n = timer + 1'b1;
                if (pb_s) begin
                    state_n = S_HOLD;
                    timer_n = '0;
                    rcnt_n  = '0;
                end else if (timer == DEB_T) begin
                    state_n = S_REL;
                end
            end
            S_REL: begin
                timer_n = '0;
                state_n = S_IDLE;
            end
            default: begin
                timer_n = '0;
                rcnt_n  = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign {DPB, SCEN, MCEN, CCEN, RLEN} = out_dec(state);

endmodule

// File: rtl/btn_rpt_deb.sv
// N-channel push-button conditioner: one independent
// debounce/repeat channel per button.
module btn_rpt_deb
    import deb_pkg::*;
#(
    parameter int N_CH     = 5,
    parameter int DEB_CYC  = 8_400_000,
    parameter int HOLD_CYC = 134_000_000,
    parameter int RPT_CYC  = 50_000_000,
    parameter int MAX_RPT  = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [N_CH-1:0] PB,
    output logic [N_CH-1:0] DPB,
    output logic [N_CH-1:0] SCEN,
    output logic [N_CH-1:0] MCEN,
    output logic [N_CH-1:0] CCEN,
    output logic [N_CH-1:0] RLEN
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_rpt_deb_ch #(
            .DEB_CYC (DEB_CYC),
            .HOLD_CYC(HOLD_CYC),
            .RPT_CYC (RPT_CYC),
            .MAX_RPT (MAX_RPT)
        ) u_ch (
            .CLK  (CLK),
            .RESET(RESET),
            .PB   (PB[i]),
            .DPB  (DPB[i]),
            .SCEN (SCEN[i]),
            .MCEN (MCEN[i]),
            .CCEN (CCEN[i]),
            .RLEN (RLEN[i])
        );
    end

endmodule

// File: tb/tb_btn_rpt_deb.sv
// Directed bench for btn_rpt_deb: glitch, press/repeat/saturate,
// release bounce, concurrency, reset and a no-repeat build.
module tb_btn_rpt_deb;

    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_PRESS = 5'b11110;
    localparam logic [4:0] O_HOLD  = 5'b10000;
    localparam logic [4:0] O_RPT   = 5'b10110;
    localparam logic [4:0] O_RWAIT = 5'b10010;
    localparam logic [4:0] O_SAT   = 5'b10110;
    localparam logic [4:0] O_RELW  = 5'b10000;
    localparam logic [4:0] O_REL   = 5'b00001;

    logic       CLK;
    logic       RESET;
    logic [1:0] PB;
    logic [1:0] DPB, SCEN, MCEN, CCEN, RLEN;
    logic [0:0] pz;
    logic [0:0] z_dpb, z_scen, z_mcen, z_ccen, z_rlen;

    int n_chk;
    int n_err;

    btn_rpt_deb #(
        .N_CH(2), .DEB_CYC(4), .HOLD_CYC(10),
        .RPT_CYC(6), .MAX_RPT(3)
    ) u_dut (
        .CLK(CLK), .RESET(RESET), .PB(PB),
        .DPB(DPB), .SCEN(SCEN), .MCEN(MCEN),
        .CCEN(CCEN), .RLEN(RLEN)
    );

    btn_rpt_deb #(
        .N_CH(1), .DEB_CYC(4), .HOLD_CYC(10),
        .RPT_CYC(6), .MAX_RPT(0)
    ) u_dz (
        .CLK(CLK), .RESET(RESET), .PB(pz),
        .DPB(z_dpb), .SCEN(z_scen), .MCEN(z_mcen),
        .CCEN(z_ccen), .RLEN(z_rlen)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] ob(input int c);
        return {DPB[c], SCEN[c], MCEN[c], CCEN[c], RLEN[c]};
    endfunction

    function automatic logic [4:0] zb();
        return {z_dpb, z_scen, z_mcen, z_ccen, z_rlen};
    endfunction

    // Clean press sampled from edge 1, released after edge 40
    function automatic logic [4:0] exp_a(input int k);
        if (k == 7) return O_PRESS;
        if (k >= 8 && k <= 17) return O_HOLD;
        if (k == 18 || k == 25 || k == 32) return O_RPT;
        if (k >= 19 && k <= 31) return O_RWAIT;
        if (k >= 33 && k <= 42) return O_SAT;
        if (k >= 43 && k <= 46) return O_RELW;
        if (k == 47) return O_REL;
        return O_IDLE;
    endfunction

    // Press, 2-cycle release bounce at edges 21-22, final release
    function automatic logic pb_b(input int k);
        return (k <= 20) || (k >= 23 && k <= 45);
    endfunction

    function automatic logic [4:0] exp_b(input int k);
        if (k == 7) return O_PRESS;
        if (k >= 8 && k <= 17) return O_HOLD;
        if (k == 18 || k == 35 || k == 42) return O_RPT;
        if (k >= 19 && k <= 22) return O_RWAIT;
        if (k == 23 || k == 24) return O_RELW;
        if (k >= 25 && k <= 34) return O_HOLD;
        if (k >= 36 && k <= 47) return O_RWAIT;
        if (k >= 48 && k <= 51) return O_RELW;
        if (k == 52) return O_REL;
        return O_IDLE;
    endfunction

    initial begin
        int zm, zc, zs;
        n_chk = 0;
        n_err = 0;
        RESET = 1'b1;
        PB    = 2'b00;
        pz    = 1'b0;
        #12;
        chk("reset ch0", 32'(ob(0)), 32'(O_IDLE));
        chk("reset ch1", 32'(ob(1)), 32'(O_IDLE));
        chk("reset z", 32'(zb()), 32'(O_IDLE));
        tick();
        tick();
        RESET = 1'b0;

        for (int k = 1; k <= 12; k++) begin
            PB[0] = (k <= 3);
            tick();
            chk($sformatf("glitch k=%0d", k),
                32'({ob(1), ob(0)}), 32'(0));
        end

        for (int k = 1; k <= 55; k++) begin
            PB[0] = (k <= 40);
            tick();
            chk($sformatf("press ch0 k=%0d", k),
                32'(ob(0)), 32'(exp_a(k)));
            chk($sformatf("press ch1 k=%0d", k),
                32'(ob(1)), 32'(O_IDLE));
        end

        for (int k = 1; k <= 60; k++) begin
            PB[0] = pb_b(k);
            tick();
            chk($sformatf("bounce k=%0d", k),
                32'(ob(0)), 32'(exp_b(k)));
        end

        for (int k = 1; k <= 40; k++) begin
            PB[0] = 1'b1;
            PB[1] = (k >= 4);
            tick();
            chk($sformatf("conc ch0 k=%0d", k),
                32'(ob(0)), 32'(exp_a(k)));
            chk($sformatf("conc ch1 k=%0d", k),
                32'(ob(1)), 32'(exp_a(k - 3)));
        end

        RESET = 1'b1;
        #1;
        chk("async reset", 32'({ob(1), ob(0)}), 32'(0));
        tick();
        chk("reset held", 32'({ob(1), ob(0)}), 32'(0));
        RESET = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("post rst ch0 k=%0d", k),
                32'(ob(0)), 32'(exp_a(k)));
            chk($sformatf("post rst ch1 k=%0d", k),
                32'(ob(1)), 32'(exp_a(k)));
        end
        PB = 2'b00;

        zm = 0;
        zc = 0;
        zs = 0;
        for (int k = 1; k <= 100; k++) begin
            pz = 1'b1;
            tick();
            zm += int'(z_mcen);
            zc += int'(z_ccen);
            zs += int'(z_scen);
            if (k == 7)
                chk("norpt press", 32'(zb()), 32'(O_PRESS));
            if (k == 100)
                chk("norpt hold", 32'(zb()), 32'(O_HOLD));
        end
        chk("norpt mcen cnt", 32'(zm), 32'(1));
        chk("norpt ccen cnt", 32'(zc), 32'(1));
        chk("norpt scen cnt", 32'(zs), 32'(1));
        for (int k = 101; k <= 110; k++) begin
            pz = 1'b0;
            tick();
            if (k == 103)
                chk("norpt relw", 32'(zb()), 32'(O_RELW));
            if (k == 107)
                chk("norpt rel", 32'(zb()), 32'(O_REL));
            if (k == 108)
                chk("norpt idle", 32'(zb()), 32'(O_IDLE));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
